// File: rtl/adc_spi_responder.sv
// SPI slave emulating an 8-channel 12-bit serial ADC: decodes the channel from each
// 16-bit command and returns the sample addressed by the previous frame.
module adc_spi_responder #(
  parameter int CHANNELS  = 8,
  parameter int DATA_BITS = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sclk,
  input  logic                          ss,
  input  logic                          mosi,
  output logic                          miso,
  input  logic [CHANNELS*DATA_BITS-1:0] samples,
  output logic [2:0]                    conv_channel,
  output logic [15:0]                   last_cmd,
  output logic                          frame_done,
  output logic                          frame_err
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Stage [1] is the synchronized level, stage [2] its one-clk-old copy for edge detect.
  logic [2:0]           sclk_sync_r;
  logic [2:0]           ss_sync_r;
  logic [1:0]           mosi_sync_r;
  logic                 sclk_rise_s;
  logic                 sclk_fall_s;
  logic                 ss_rise_s;
  logic                 ss_fall_s;

  state_t               state_r;
  state_t               state_s;
  logic [15:0]          tx_sr_r;
  logic [15:0]          tx_sr_s;
  logic [15:0]          rx_sr_r;
  logic [15:0]          rx_sr_s;
  logic [4:0]           bit_cnt_r;
  logic [4:0]           bit_cnt_s;
  logic                 miso_r;
  logic                 miso_s;
  logic [2:0]           conv_channel_r;
  logic [2:0]           conv_channel_s;
  logic [15:0]          last_cmd_r;
  logic [15:0]          last_cmd_s;
  logic                 frame_done_r;
  logic                 frame_done_s;
  logic                 frame_err_r;
  logic                 frame_err_s;
  logic [DATA_BITS-1:0] sel_sample_s;

  // Synchronizers run through reset so a select already high is not seen as a new edge.
  always_ff @(posedge clk) begin
    sclk_sync_r <= {sclk_sync_r[1:0], sclk};
    ss_sync_r   <= {ss_sync_r[1:0], ss};
    mosi_sync_r <= {mosi_sync_r[0], mosi};
  end

  // Edge detection on the synchronized pins.
  always_comb begin
    sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
    sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
    ss_rise_s   = ss_sync_r[1] & ~ss_sync_r[2];
    ss_fall_s   = ~ss_sync_r[1] & ss_sync_r[2];
  end

  // Sample mux; unpopulated channel addresses read as zero.
  always_comb begin
    sel_sample_s = {DATA_BITS{1'b0}};
    for (int n = 0; n < CHANNELS; n++) begin
      sel_sample_s = (conv_channel_r == 3'(n)) ? samples[n*DATA_BITS +: DATA_BITS] : sel_sample_s;
    end
  end

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_s        = state_r;
    tx_sr_s        = tx_sr_r;
    rx_sr_s        = rx_sr_r;
    bit_cnt_s      = bit_cnt_r;
    miso_s         = miso_r;
    conv_channel_s = conv_channel_r;
    last_cmd_s     = last_cmd_r;
    frame_done_s   = 1'b0;
    frame_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ss_rise_s) begin
          state_s   = ST_SHIFT;
          tx_sr_s   = 16'(sel_sample_s);
          rx_sr_s   = 16'h0000;
          bit_cnt_s = 5'd0;
          miso_s    = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Select release takes priority over a coincident clock edge.
        if (ss_fall_s) begin
          state_s = ST_IDLE;
          miso_s  = 1'b0;
          if (bit_cnt_r == 5'd16) begin
            last_cmd_s     = rx_sr_r;
            conv_channel_s = rx_sr_r[13:11];
            frame_done_s   = 1'b1;
          end else begin
            frame_err_s = 1'b1;
          end
        end else if (sclk_rise_s) begin
          miso_s  = tx_sr_r[15];
          tx_sr_s = {tx_sr_r[14:0], 1'b0};
        end else if (sclk_fall_s) begin
          rx_sr_s   = {rx_sr_r[14:0], mosi_sync_r[1]};
          bit_cnt_s = (bit_cnt_r == 5'd31) ? bit_cnt_r : bit_cnt_r + 5'd1;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: begin
        state_s = ST_IDLE;
        miso_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      tx_sr_r        <= 16'h0000;
      rx_sr_r        <= 16'h0000;
      bit_cnt_r      <= 5'd0;
      miso_r         <= 1'b0;
      conv_channel_r <= 3'd0;
      last_cmd_r     <= 16'h0000;
      frame_done_r   <= 1'b0;
      frame_err_r    <= 1'b0;
    end else begin
      state_r        <= state_s;
      tx_sr_r        <= tx_sr_s;
      rx_sr_r        <= rx_sr_s;
      bit_cnt_r      <= bit_cnt_s;
      miso_r         <= miso_s;
      conv_channel_r <= conv_channel_s;
      last_cmd_r     <= last_cmd_s;
      frame_done_r   <= frame_done_s;
      frame_err_r    <= frame_err_s;
    end
  end

  assign miso         = miso_r;
  assign conv_channel = conv_channel_r;
  assign last_cmd     = last_cmd_r;
  assign frame_done   = frame_done_r;
  assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: an 8-channel instance and a 2-channel
// instance share one SPI bus; responses are checked against hand-computed values.
module tb_adc_spi_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        ss = 1'b0;
  logic        mosi = 1'b0;
  logic        miso_a;
  logic        miso_b;
  logic [95:0] samples_a = 96'h0;
  logic [23:0] samples_b = 24'h0;
  logic [2:0]  conv_a;
  logic [2:0]  conv_b;
  logic [15:0] last_a;
  logic [15:0] last_b;
  logic        done_a;
  logic        done_b;
  logic        err_a;
  logic        err_b;

  int n_assert = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic chg_en = 1'b0;

  adc_spi_responder #(.CHANNELS(8), .DATA_BITS(12)) dut_a (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso_a),
    .samples(samples_a), .conv_channel(conv_a), .last_cmd(last_a),
    .frame_done(done_a), .frame_err(err_a));

  adc_spi_responder #(.CHANNELS(2), .DATA_BITS(12)) dut_b (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso_b),
    .samples(samples_b), .conv_channel(conv_b), .last_cmd(last_b),
    .frame_done(done_b), .frame_err(err_b));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done_a) done_cnt <= done_cnt + 1;
    if (err_a) err_cnt <= err_cnt + 1;
    if (done_a && err_a) both_cnt <= both_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic b, output logic ma, output logic mb);
    mosi = b;
    sclk = 1'b1;
    tick(6);
    ma = miso_a;
    mb = miso_b;
    sclk = 1'b0;
    tick(6);
  endtask

  task automatic frame(input logic [15:0] cmd, input int nbits,
                       output logic [15:0] ra, output logic [15:0] rb);
    logic ma, mb;
    ra = 16'h0;
    rb = 16'h0;
    ss = 1'b1;
    tick(6);
    for (int i = 0; i < nbits; i++) begin
      if (chg_en && i == 8) samples_a[23:12] = 12'h555;
      xfer(cmd[15-i], ma, mb);
      ra[15-i] = ma;
      rb[15-i] = mb;
    end
    ss = 1'b0;
    tick(8);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        ma, mb;
    int          d0, e0;

    tick(5);
    reset = 1'b0;
    tick(2);
    check("rst_miso", 32'(miso_a), 32'h0);
    check("rst_conv", 32'(conv_a), 32'h0);
    check("rst_last_cmd", 32'(last_a), 32'h0);
    check("rst_done", 32'(done_a), 32'h0);
    check("rst_err", 32'(err_a), 32'h0);

    // Basic pipelined read
    samples_a[11:0]  = 12'h123;
    samples_a[23:12] = 12'hFF0;
    samples_b[11:0]  = 12'h0AB;
    samples_b[23:12] = 12'h0CD;
    frame(16'h0800, 16, ra, rb);
    check("f1_resp", 32'(ra), 32'h0123);
    check("f1_resp_b", 32'(rb), 32'h00AB);
    check("f1_last_cmd", 32'(last_a), 32'h0800);
    check("f1_conv", 32'(conv_a), 32'h1);
    check("f1_done_cnt", 32'(done_cnt), 32'd1);
    check("f1_err_cnt", 32'(err_cnt), 32'd0);
    frame(16'h0800, 16, ra, rb);
    check("f2_resp", 32'(ra), 32'h0FF0);
    check("f2_resp_b", 32'(rb), 32'h00CD);
    check("f2_done_cnt", 32'(done_cnt), 32'd2);

    // Channel sweep: prime with channel 0, then each frame reads the previous address
    for (int n = 0; n < 8; n++) samples_a[n*12 +: 12] = 12'h100 + 12'(n);
    frame(16'h0000, 16, ra, rb);
    check("sweep_prime", 32'(ra), 32'h0101);
    for (int n = 0; n < 8; n++) begin
      frame(16'(((n + 1) % 8) << 11), 16, ra, rb);
      check("sweep_resp", 32'(ra), 32'h100 + 32'(n));
    end
    check("sweep_conv", 32'(conv_a), 32'h0);

    // Short frame addressing channel 5
    d0 = done_cnt;
    e0 = err_cnt;
    frame(16'h2800, 10, ra, rb);
    check("short_err", 32'(err_cnt - e0), 32'd1);
    check("short_done", 32'(done_cnt - d0), 32'd0);
    check("short_conv", 32'(conv_a), 32'h0);
    check("short_last_cmd", 32'(last_a), 32'h0000);
    frame(16'h0800, 16, ra, rb);
    check("after_short_resp", 32'(ra), 32'h0100);
    check("after_short_conv", 32'(conv_a), 32'h1);

    // Sample change mid-frame
    samples_a[23:12] = 12'hAAA;
    chg_en = 1'b1;
    frame(16'h0800, 16, ra, rb);
    chg_en = 1'b0;
    check("midchg_resp", 32'(ra), 32'h0AAA);
    frame(16'h0800, 16, ra, rb);
    check("midchg_next", 32'(ra), 32'h0555);

    // Reset after 7 clock cycles of a frame; bit 9 of 0x0FFF is 1
    samples_a[23:12] = 12'hFFF;
    d0 = done_cnt;
    e0 = err_cnt;
    ss = 1'b1;
    tick(6);
    for (int i = 0; i < 7; i++) xfer(1'b0, ma, mb);
    check("prerst_miso", 32'(miso_a), 32'h1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("midrst_miso", 32'(miso_a), 32'h0);
    check("midrst_conv", 32'(conv_a), 32'h0);
    check("midrst_last_cmd", 32'(last_a), 32'h0);
    xfer(1'b0, ma, mb);
    check("midrst_idle_miso", 32'(miso_a), 32'h0);
    ss = 1'b0;
    tick(8);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    frame(16'h0000, 16, ra, rb);
    check("postrst_resp", 32'(ra), 32'h0100);

    // Out-of-range address on the 2-channel instance
    frame(16'h3000, 16, ra, rb);
    check("oor_conv_b", 32'(conv_b), 32'h6);
    frame(16'h0000, 16, ra, rb);
    check("oor_resp_a", 32'(ra), 32'h0106);
    check("oor_resp_b", 32'(rb), 32'h0000);
    check("strobe_exclusive", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable SPI slave that emulates an 8-channel, 12-bit serial ADC of the ADC082S021/ADCx28S family. It is the device-side counterpart of the adc082s021 driver run under spi_master_ctrl. It decodes the 3-bit channel address from each 16-bit command frame and shifts back a converted sample taken from a parallel sample bus. It serves as a bench model and a loopback/bring-up target, and it lets an FPGA impersonate an ADC toward an external master.

## Interface
Parameters:
- CHANNELS, 8 — number of sample inputs, 1..8; addresses >= CHANNELS return 0.
- DATA_BITS, 12 — sample width, 1..12; sent right-justified in the 16-bit frame.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock from master, asynchronous to clk; idles low.
- ss  in  1  slave select, active high (codebase convention); asynchronous.
- mosi  in  1  command data from master, asynchronous.
- miso  out  1  response data to master; reset value 0.
- samples  in  CHANNELS*DATA_BITS  parallel samples; channel n is at [n*DATA_BITS +: DATA_BITS].
- conv_channel  out  3  channel latched for the next conversion; reset value 0.
- last_cmd  out  16  last complete command frame received; reset value 0.
- frame_done  out  1  one-clk strobe after a valid 16-bit frame; reset value 0.
- frame_err  out  1  one-clk strobe after a frame with a bit count other than 16; reset value 0.

## Operation
- Input conditioning: sclk, ss and mosi each pass through a 2-flop synchronizer. Edges are detected on the synchronized signals.
- States: IDLE, SHIFT.
- IDLE → SHIFT on the rising edge of ss:
  - Load tx_sr = {(16-DATA_BITS) zeros, sample[conv_channel]}. Use 0 if conv_channel >= CHANNELS.
  - Clear rx_sr and bit_cnt (5 bits). Drive miso = 0.
- SHIFT, sclk rising edge: miso ← tx_sr[15], tx_sr shifts left with zero fill. Sixteen rising edges present bits 15..0, MSB first.
- SHIFT, sclk falling edge: rx_sr ← {rx_sr[14:0], mosi_sync}. bit_cnt increments and saturates at 31.
- SHIFT → IDLE on the falling edge of ss:
  - If bit_cnt == 16: last_cmd ← rx_sr, conv_channel ← rx_sr[13:11], frame_done pulses.
  - Otherwise: frame_err pulses and conv_channel and last_cmd are unchanged.
  - miso ← 0 in both cases.
- Pipelined addressing, as on the real part: frame N returns the conversion of the channel addressed in frame N-1. The first frame after reset returns channel 0.
- Sample latch point: samples are captured once, at ss assertion. Changes on samples during a frame do not affect that frame.
- Edge ordering: if ss falls in the same clk as an sclk edge, the ss event wins and the sclk edge is ignored.
- Edges outside a frame: sclk edges while in IDLE are ignored.
- Other command bits: bits other than [13:11] are ignored. They are still stored in last_cmd.

## Timing
- Each pin event takes effect 3 clk after the pin edge: 2 synchronizer stages plus 1 registered edge detect.
- miso changes 3 clk after sclk rises, so it is stable well before the next sclk fall, when the master samples it.
- Requirements on the master:
  - sclk high and low phases each >= 4 clk.
  - ss setup to the first sclk rise >= 4 clk.
  - ss hold after the last sclk fall >= 4 clk.
- frame_done and frame_err assert 3 clk after ss falls, for exactly 1 clk. They are mutually exclusive.
- conv_channel and last_cmd update in the same clk as frame_done.
- Reset mid-frame:
  - All outputs return to their reset values and the FSM returns to IDLE.
  - An ss that is already high is not treated as a new frame. A rising edge of ss is required, so the current partial frame is discarded without asserting frame_err.

## Test plan
- Reset, then frame with cmd 0x0800, samples ch0=0x123 and ch1=0xFF0 → miso frame 0x0123. Afterwards last_cmd=0x0800, conv_channel=1, frame_done pulses once. Second frame with cmd 0x0800 → miso frame 0x0FF0.
- Sweep channels 0..7 with samples 0x100+n, each frame addressing (n+1)%8 → each response equals the sample addressed by the previous frame, and the top 4 bits are always 0.
- Short frame of 10 sclk cycles with cmd bits for channel 5 → frame_err pulses, frame_done does not, conv_channel is unchanged. The next 16-bit frame works normally.
- Change samples[ch1] from 0xAAA to 0x555 mid-frame → that frame returns 0xAAA and the following frame returns 0x555.
- Assert reset after 7 sclk cycles → miso=0 and conv_channel=0 immediately, no strobe on the subsequent ss fall. The next full frame returns the channel 0 sample.
- CHANNELS=2 instance addressed with channel 6 → the next frame returns 0x0000.
